// File: rtl/pc_fetch_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_stage_pkg
//  Description : Shared widths, reset PC and fetch FSM encodings for the
//                instruction-fetch stage.
//  Revision    : 1.0  initial release
// ============================================================================
package pc_fetch_stage_pkg;

   localparam int          C_ADDR_W   = 32;
   localparam int          C_INSTR_W  = 32;
   localparam logic [31:0] C_RESET_PC = 32'h0000_0000;

   // Fetch sequencer states (2-bit encoding)
   typedef enum logic [1:0] {
      ST_START = 2'd0,
      ST_REQ   = 2'd1,
      ST_DROP  = 2'd2,
      ST_HOLD  = 2'd3
   } fetch_state_t;

   // A memory request is open in REQ (live fetch) and DROP (fetch being discarded)
   function automatic logic is_req_state(input fetch_state_t st);
      return (st == ST_REQ) || (st == ST_DROP);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pc_fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_stage_if
//  Description : Fetch-stage bundle: next-PC adder loop, instruction-memory
//                req/ack port, pipeline control and IF/ID register outputs.
//  Revision    : 1.0  initial release
// ============================================================================
interface pc_fetch_stage_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
);
   logic [ADDR_W-1:0]  newAddress;
   logic [ADDR_W-1:0]  currentAddress;
   logic               imemReq;
   logic [ADDR_W-1:0]  imemAddr;
   logic               imemAck;
   logic [INSTR_W-1:0] imemData;
   logic               stall;
   logic               flush;
   logic               ifidValid;
   logic [INSTR_W-1:0] ifidInstr;
   logic [ADDR_W-1:0]  ifidPC;

   // Fetch stage side
   modport master (
      input  newAddress, imemAck, imemData, stall, flush,
      output currentAddress, imemReq, imemAddr, ifidValid, ifidInstr, ifidPC
   );

   // Surrounding pipeline / memory side
   modport slave (
      output newAddress, imemAck, imemData, stall, flush,
      input  currentAddress, imemReq, imemAddr, ifidValid, ifidInstr, ifidPC
   );
endinterface
`default_nettype wire

// File: rtl/pc_fetch_stage_skid.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_stage_skid
//  Description : One-entry skid buffer holding {instr, pc} for a fetch that
//                completed while ID was stalled. Clear beats load beats drain.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_stage_skid #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic               drain,
   input  logic               clear,
   input  logic [INSTR_W-1:0] load_instr,
   input  logic [ADDR_W-1:0]  load_pc,
   output logic               full,
   output logic [INSTR_W-1:0] instr,
   output logic [ADDR_W-1:0]  pc
);

   logic               r_full;
   logic [INSTR_W-1:0] r_instr;
   logic [ADDR_W-1:0]  r_pc;

   // Capture, drain or discard the parked instruction
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_full  <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (clear) begin
         r_full  <= 1'b0;
      end else if (load) begin
         r_full  <= 1'b1;
         r_instr <= load_instr;
         r_pc    <= load_pc;
      end else if (drain) begin
         r_full  <= 1'b0;
      end
   end

   assign full  = r_full;
   assign instr = r_instr;
   assign pc    = r_pc;

endmodule
`default_nettype wire

// File: rtl/pc_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : pc_fetch_stage
//  Description : Instruction-fetch stage. Owns the PC register, issues req/ack
//                reads to instruction memory and fills the IF/ID register,
//                with a one-entry skid for ID stalls and branch/jump flush.
//  Revision    : 1.0  initial release
// ============================================================================
module pc_fetch_stage
   import pc_fetch_stage_pkg::*;
#(
   parameter int                 ADDR_W   = C_ADDR_W,
   parameter int                 INSTR_W  = C_INSTR_W,
   parameter logic [ADDR_W-1:0]  RESET_PC = C_RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   pc_fetch_stage_if.master  bus
);

   fetch_state_t       r_state;
   logic [ADDR_W-1:0]  r_pc;
   logic               r_ifid_valid;
   logic [INSTR_W-1:0] r_ifid_instr;
   logic [ADDR_W-1:0]  r_ifid_pc;

   logic               w_skid_load;
   logic               w_skid_drain;
   logic               w_skid_clear;
   logic               w_skid_full;
   logic [INSTR_W-1:0] w_skid_instr;
   logic [ADDR_W-1:0]  w_skid_pc;

   // Skid control: park an ack that arrives under stall, release it once ID frees up
   assign w_skid_clear = bus.flush;
   assign w_skid_load  = (r_state == ST_REQ)  &&  bus.imemAck && bus.stall && !bus.flush;
   assign w_skid_drain = (r_state == ST_HOLD) && !bus.stall && !bus.flush;

   pc_fetch_stage_skid #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W)
   ) u_skid (
      .clk        (clk),
      .reset      (reset),
      .load       (w_skid_load),
      .drain      (w_skid_drain),
      .clear      (w_skid_clear),
      .load_instr (bus.imemData),
      .load_pc    (r_pc),
      .full       (w_skid_full),
      .instr      (w_skid_instr),
      .pc         (w_skid_pc)
   );

   // Fetch sequencer, PC register and IF/ID register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_START;
         r_pc         <= RESET_PC;
         r_ifid_valid <= 1'b0;
         r_ifid_instr <= '0;
         r_ifid_pc    <= '0;
      end else if (bus.flush) begin
         // Redirect wins over everything; an unanswered request must still be
         // retired, so REQ without ack waits in DROP for the stale data.
         r_ifid_valid <= 1'b0;
         r_pc         <= bus.newAddress;
         case (r_state)
            ST_REQ:  r_state <= bus.imemAck ? ST_REQ : ST_DROP;
            ST_DROP: r_state <= bus.imemAck ? ST_REQ : ST_DROP;
            default: r_state <= ST_REQ;
         endcase
      end else begin
         case (r_state)
            ST_START: begin
               r_state <= ST_REQ;
            end
            ST_REQ: begin
               if (bus.imemAck && !bus.stall) begin
                  r_ifid_valid <= 1'b1;
                  r_ifid_instr <= bus.imemData;
                  r_ifid_pc    <= r_pc;
                  r_pc         <= bus.newAddress;
               end else if (bus.imemAck) begin
                  // Data went into the skid; stop requesting until it drains
                  r_pc    <= bus.newAddress;
                  r_state <= ST_HOLD;
               end else if (!bus.stall) begin
                  r_ifid_valid <= 1'b0;
               end
            end
            ST_DROP: begin
               if (bus.imemAck) begin
                  r_state <= ST_REQ;
               end
            end
            ST_HOLD: begin
               if (!bus.stall) begin
                  r_ifid_valid <= w_skid_full;
                  r_ifid_instr <= w_skid_instr;
                  r_ifid_pc    <= w_skid_pc;
                  r_state      <= ST_REQ;
               end
            end
            default: begin
               r_state <= ST_START;
            end
         endcase
      end
   end

   assign bus.currentAddress = r_pc;
   assign bus.imemAddr       = r_pc;
   assign bus.imemReq        = is_req_state(r_state);
   assign bus.ifidValid      = r_ifid_valid;
   assign bus.ifidInstr      = r_ifid_instr;
   assign bus.ifidPC         = r_ifid_pc;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pc_fetch_stage
//  Description : Table-driven bench for the fetch stage with a few hand-written
//                sequences for asynchronous reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pc_fetch_stage;

   logic        clk;
   logic        reset;
   logic        redir;
   logic [31:0] target;

   int n_vec;
   int n_bad;

   pc_fetch_stage_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

   pc_fetch_stage #(
      .ADDR_W   (32),
      .INSTR_W  (32),
      .RESET_PC (32'h0000_0000)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Instruction memory contents as seen at the read address
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a == 32'h8) ? 32'h2002_0005 : {16'hC0DE, a[15:0]};
   endfunction

   // Next-PC adder: sequential +4 unless a redirect target is applied
   assign bus.newAddress = redir ? target : bus.currentAddress + 32'd4;
   assign bus.imemData   = mem_word(bus.imemAddr);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        ack;
      logic        stall;
      logic        flush;
      logic        redir;
      logic [31:0] target;
      logic        e_valid;
      logic        e_req;
      logic [31:0] e_addr;
      logic        chk_data;
      logic [31:0] e_pc;
      logic [31:0] e_instr;
   } vec_t;

   vec_t vq[$];

   task automatic add(input logic rst, input logic ack, input logic stall,
                      input logic flush, input logic rd, input logic [31:0] tgt,
                      input logic e_valid, input logic e_req,
                      input logic [31:0] e_addr, input logic [31:0] e_pc);
      vec_t v;
      v.rst      = rst;
      v.ack      = ack;
      v.stall    = stall;
      v.flush    = flush;
      v.redir    = rd;
      v.target   = tgt;
      v.e_valid  = e_valid;
      v.e_req    = e_req;
      v.e_addr   = e_addr;
      v.chk_data = e_valid | rst;
      v.e_pc     = rst ? 32'h0 : e_pc;
      v.e_instr  = rst ? 32'h0 : mem_word(e_pc);
      vq.push_back(v);
   endtask

   task automatic check(input string name, input logic e_valid, input logic e_req,
                        input logic [31:0] e_addr, input logic chk_data,
                        input logic [31:0] e_pc, input logic [31:0] e_instr);
      logic ok;
      n_vec++;
      ok = (bus.ifidValid === e_valid) && (bus.imemReq === e_req) &&
           (bus.imemAddr === e_addr) && (bus.currentAddress === e_addr);
      if (chk_data)
         ok = ok && (bus.ifidPC === e_pc) && (bus.ifidInstr === e_instr);
      if (!ok) begin
         n_bad++;
         $display("FAIL %s: got valid=%b req=%b addr=%h cur=%h pc=%h instr=%h ; want valid=%b req=%b addr=%h pc=%h instr=%h (data checked=%b)",
                  name, bus.ifidValid, bus.imemReq, bus.imemAddr, bus.currentAddress,
                  bus.ifidPC, bus.ifidInstr, e_valid, e_req, e_addr, e_pc, e_instr, chk_data);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_vec       = 0;
      n_bad       = 0;
      reset       = 1'b1;
      redir       = 1'b0;
      target      = 32'h0;
      bus.imemAck = 1'b0;
      bus.stall   = 1'b0;
      bus.flush   = 1'b0;

      // ---- sequential fetch, zero-wait memory
      add(0,1,0,0, 0,32'h0,   0,1,32'h0,   32'h0);   // START -> REQ
      add(0,1,0,0, 0,32'h0,   1,1,32'h4,   32'h0);
      add(0,1,0,0, 0,32'h0,   1,1,32'h8,   32'h4);
      add(0,1,0,0, 0,32'h0,   1,1,32'hC,   32'h8);
      add(0,1,0,0, 0,32'h0,   1,1,32'h10,  32'hC);
      // ---- two-cycle memory: bubbles alternate, address held while waiting
      add(0,0,0,0, 0,32'h0,   0,1,32'h10,  32'hC);
      add(0,1,0,0, 0,32'h0,   1,1,32'h14,  32'h10);
      add(0,0,0,0, 0,32'h0,   0,1,32'h14,  32'h10);
      add(0,1,0,0, 0,32'h0,   1,1,32'h18,  32'h14);
      // ---- reset, then stall over the ack of PC=8
      add(1,1,0,0, 0,32'h0,   0,0,32'h0,   32'h0);
      add(0,1,0,0, 0,32'h0,   0,1,32'h0,   32'h0);
      add(0,1,0,0, 0,32'h0,   1,1,32'h4,   32'h0);
      add(0,1,0,0, 0,32'h0,   1,1,32'h8,   32'h4);
      add(0,1,1,0, 0,32'h0,   1,0,32'hC,   32'h4);   // ack under stall -> HOLD
      add(0,1,1,0, 0,32'h0,   1,0,32'hC,   32'h4);
      add(0,1,1,0, 0,32'h0,   1,0,32'hC,   32'h4);
      add(0,1,0,0, 0,32'h0,   1,1,32'hC,   32'h8);   // skid drains PC=8
      add(0,1,0,0, 0,32'h0,   1,1,32'h10,  32'hC);
      // ---- flush with request open at 16, ack two cycles later
      add(0,0,0,1, 1,32'h40,  0,1,32'h40,  32'h0);   // -> DROP
      add(0,0,0,0, 0,32'h0,   0,1,32'h40,  32'h0);
      add(0,1,0,0, 0,32'h0,   0,1,32'h40,  32'h0);   // stale ack discarded
      add(0,1,0,0, 0,32'h0,   1,1,32'h44,  32'h40);
      // ---- flush and stall together while in HOLD
      add(0,1,1,0, 0,32'h0,   1,0,32'h48,  32'h40);  // parks PC=44
      add(0,0,1,1, 1,32'h100, 0,1,32'h100, 32'h0);
      add(0,1,0,0, 0,32'h0,   1,1,32'h104, 32'h100); // PC=44 never appears
      // ---- flush again while in DROP reloads the PC
      add(0,0,0,1, 1,32'h200, 0,1,32'h200, 32'h0);
      add(0,0,0,1, 1,32'h300, 0,1,32'h300, 32'h0);
      add(0,1,0,0, 0,32'h0,   0,1,32'h300, 32'h0);
      add(0,1,0,0, 0,32'h0,   1,1,32'h304, 32'h300);
      // ---- flush coinciding with ack in REQ discards the data
      add(0,1,0,1, 1,32'h500, 0,1,32'h500, 32'h0);
      add(0,1,0,0, 0,32'h0,   1,1,32'h504, 32'h500);
      // ---- PC wrap at the top of the address space
      add(0,1,0,1, 1,32'hFFFF_FFFC, 0,1,32'hFFFF_FFFC, 32'h0);
      add(0,1,0,0, 0,32'h0,   1,1,32'h0,   32'hFFFF_FFFC);
      add(0,1,0,0, 0,32'h0,   1,1,32'h4,   32'h0);

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);

      foreach (vq[i]) begin
         @(negedge clk);
         reset       = vq[i].rst;
         bus.imemAck = vq[i].ack;
         bus.stall   = vq[i].stall;
         bus.flush   = vq[i].flush;
         redir       = vq[i].redir;
         target      = vq[i].target;
         @(posedge clk);
         #1;
         check($sformatf("vec%0d", i), vq[i].e_valid, vq[i].e_req, vq[i].e_addr,
               vq[i].chk_data, vq[i].e_pc, vq[i].e_instr);
      end

      // ---- asynchronous reset with a request open and no ack
      @(negedge clk);
      reset       = 1'b0;
      bus.imemAck = 1'b0;
      bus.stall   = 1'b0;
      bus.flush   = 1'b0;
      redir       = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("async_reset", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 32'h0);
      @(negedge clk);
      reset       = 1'b0;
      bus.imemAck = 1'b1;
      @(posedge clk);
      #1;
      check("post_reset_req", 1'b0, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0);
      @(posedge clk);
      #1;
      check("post_reset_fetch", 1'b1, 1'b1, 32'h4, 1'b1, 32'h0, mem_word(32'h0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
